uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Sequencing controller for the 16x-oversampled UART receiver.
- Generates the receiver's 16x sample enable from sys_clk.
- Synchronises the raw rx pin before it reaches the receiver.
- Completes the receiver's rx_ready / rx_ready_clear handshake and buffers bytes in a small FIFO.
- Presents bytes to user logic on a valid/ready stream and flags overruns.
- Sits between the pad and the consumer, with the receiver instantiated beside it.

Parameters:
- CLK_DIV, 27, sys_clk cycles per 16x sample tick (default gives 115200 baud x16 at 50 MHz); legal range 2..65535.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..64.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_pin  in  1  raw asynchronous serial input.
- rx_sync  out  1  synchronised rx, to the receiver's rx.
- rx_clk_en  out  1  one-cycle 16x sample enable, to the receiver.
- rx_data  in  8  receiver data.
- rx_ready  in  1  receiver byte-ready flag.
- rx_ready_clear  out  1  one-cycle clear strobe, to the receiver.
- m_data  out  8  FIFO head byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accept.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous on sys_rst_n low:
  - Outputs: rx_sync=1, rx_clk_en=0, rx_ready_clear=0, m_valid=0, m_data=0, overrun=0, fifo_level=0.
  - Internal: synchroniser flops=1, divider counter=0, FSM=IDLE, FIFO pointers=0.
- Synchroniser: two flops, rx_pin -> rx_sync with 2-cycle latency.
- Divider:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - rx_clk_en=1 for exactly the one cycle where counter==CLK_DIV-1.
  - The counter is free-running and never stalls.
- Handshake FSM, evaluated every sys_clk:
  - IDLE: if rx_ready=1, capture rx_data (push attempt this cycle), drive rx_ready_clear=1 for this cycle, go to WAIT_LOW.
  - WAIT_LOW: rx_ready_clear=0; when rx_ready=0, go to IDLE. This guarantees one push per byte even if the clear takes extra cycles.
  - Capture latency: byte is visible on m_data/m_valid 1 cycle after the IDLE capture cycle when the FIFO was empty.
- FIFO:
  - Synchronous, first-word-fall-through; m_data is the head entry, registered.
  - Pop when m_valid & m_ready.
  - Push when a capture occurs and (level<FIFO_DEPTH or a pop happens in the same cycle).
  - Full with simultaneous push and pop: both occur, level unchanged.
  - Empty: m_ready is ignored, level stays 0, m_data holds its last value.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; level = pushes - pops, with width one bit wider than the pointers.
- Overrun:
  - Capture when full with no pop: byte discarded, overrun set to 1 on the next edge, handshake still completed (rx_ready_clear pulsed).
  - overrun_clr=1 clears the flag; if a set and a clear coincide, set wins.
- A reset mid-byte abandons the FIFO contents and the FSM state. The receiver's own stale rx_ready is cleared by the first IDLE capture after reset, and that capture is stored as a normal byte.

Optional Feature:
- UART_RX_CTRL_STAT_EN defined:
  - Adds output drop_count [15:0] and output byte_count [15:0], both reset to 0.
  - byte_count increments on every successful push; drop_count increments on every dropped byte.
  - Both saturate at 16'hFFFF.
  - overrun_clr also zeroes drop_count, not byte_count.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding: IDLE=1'b0, WAIT_LOW=1'b1.
  - UART_BYTE_W=8 and OVERSAMPLE=16.
  - Default CLK_DIV for the 50 MHz / 115200 configuration.
- One sub-module is natural: uart_byte_fifo (parameter DEPTH; push/pop/full/empty/level), instantiated once.
- Divider, synchroniser and FSM stay inline.

Test Plan:
- Divider, CLK_DIV=4, after reset release: rx_clk_en pulses at cycles 3, 7, 11, ... with exactly one high cycle per 4, never two consecutive.
- Single byte via a receiver model, 0xA5, m_ready=1:
  - rx_ready_clear pulses exactly once.
  - m_valid high for one cycle with m_data=0xA5.
  - fifo_level returns to 0.
- FIFO fill, m_ready=0, FIFO_DEPTH=8:
  - Send 0x00..0x08 (9 bytes).
  - First 8 stored; 0x08 dropped; overrun=1; fifo_level=8.
  - Then m_ready=1: read back 0x00..0x07 in order.
- Full plus simultaneous capture and pop: capture 0x5A in the same cycle m_ready=1 with level=8. 0x5A is stored, level stays 8, overrun stays 0.
- overrun_clr coinciding with a new drop: overrun remains 1. With UART_RX_CTRL_STAT_EN defined, drop_count goes from 1 to 1 (clear and increment collide, increment wins).
- Reset asserted while in WAIT_LOW with 3 bytes queued:
  - Immediately m_valid=0, fifo_level=0, rx_sync=1.
  - After release, a pending rx_ready=1 produces one capture and one clear pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// FSM encoding, byte width, oversample ratio, default divider.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int OVERSAMPLE  = 16;

    // 50 MHz / (115200 * 16) = 27.13, rounded down
    localparam int DEFAULT_CLK_DIV = 27;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head.
// Caller guarantees push only when not full (or popping), pop only when not empty.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_BYTE_W-1:0] din,
    output logic [UART_BYTE_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_nxt;

    assign rd_nxt = rd_ptr + 1'b1;
    assign full   = (level == FULL_LVL);
    assign empty  = (level == '0);

    // Storage array, written on push only
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nxt;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop) begin
                if (level != ONE_LVL) dout <= mem[rd_nxt];
                else if (push)        dout <= din;
            end else if (push && empty) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the 16x-oversampled UART receiver.
// Optional statistics counters: define UART_RX_CTRL_STAT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter  int FIFO_DEPTH = 8,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   rx_pin,
    output logic                   rx_sync,
    output logic                   rx_clk_en,
    input  logic [UART_BYTE_W-1:0] rx_data,
    input  logic                   rx_ready,
    output logic                   rx_ready_clear,
    output logic [UART_BYTE_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [LW-1:0]          fifo_level
`ifdef UART_RX_CTRL_STAT_EN
    ,
    output logic [15:0]            drop_count,
    output logic [15:0]            byte_count
`endif
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic      sync_q1;
    logic [15:0] div_cnt;
    rx_state_e state;
    logic      capture;
    logic      pop;
    logic      push;
    logic      drop;
    logic      full;
    logic      empty;

    // Two-flop synchroniser, idles high like the line
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync_q1 <= rx_pin;
            rx_sync <= sync_q1;
        end
    end

    // Free-running 16x tick divider
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)              div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                         div_cnt <= div_cnt + 1'b1;
    end

    assign rx_clk_en = (div_cnt == DIV_LAST);

    // Capture once per rx_ready pulse; rearm only after it drops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            unique case (1'b1)
                (state == IDLE):     if (rx_ready)  state <= WAIT_LOW;
                (state == WAIT_LOW): if (!rx_ready) state <= IDLE;
            endcase
        end
    end

    // Reset gating keeps the clear strobe low while held in reset
    assign capture        = (state == IDLE) & rx_ready & sys_rst_n;
    assign rx_ready_clear = capture;

    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    uart_byte_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .pop       (pop),
        .din       (rx_data),
        .dout      (m_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Sticky overrun; a new drop beats a coincident clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

`ifdef UART_RX_CTRL_STAT_EN
    // Saturating byte and drop counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_count <= '0;
            drop_count <= '0;
        end else begin
            if (push && byte_count != 16'hFFFF)
                byte_count <= byte_count + 1'b1;
            if (drop) begin
                if (overrun_clr)                drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end else if (overrun_clr) begin
                drop_count <= '0;
            end
        end
    end
`endif

endmodule
